// File: rtl/led_gpio_arbiter_pkg.sv
// Shared LED/GPIO controller definitions: FSM encodings, default timing
// constants (also used by the GPIO/shifter wrapper) and a counter-width helper.
package led_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int DEF_SHIFT_CYCLES   = 40;
  localparam int DEF_REFRESH_PERIOD = 1000000;

  // Counter width for a bound n, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_gpio_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import led_ctrl_defs::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [cw(NUM_REQ)-1:0]     ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [cw(NUM_REQ)-1:0]     idx,
  output logic                       vld
);

  localparam int PW = cw(NUM_REQ);

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        idx    = PW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_gpio_arbiter.sv
// Round-robin owner of the LED GPIO register and its serial shifter, with
// periodic idle re-shift so the board LEDs stay refreshed.
module led_gpio_arbiter
  import led_ctrl_defs::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int SHIFT_CYCLES   = DEF_SHIFT_CYCLES,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        gpio_en,
  output logic [DATA_W-1:0]           gpio_data,
  output logic                        p2s_start,
  output logic                        busy
);

  localparam int PW = cw(NUM_REQ);
  localparam int SW = cw(SHIFT_CYCLES);
  localparam int RW = cw(REFRESH_PERIOD);
  localparam logic [SW-1:0] SLAST = SW'(SHIFT_CYCLES - 1);
  localparam logic [RW-1:0] RLAST = RW'((REFRESH_PERIOD == 0) ? 0 : REFRESH_PERIOD - 1);
  localparam logic [PW-1:0] PLAST = PW'(NUM_REQ - 1);

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [SW-1:0]        r_wcnt;
  logic [RW-1:0]        r_rcnt;
  logic [NUM_REQ-1:0]   r_ack, r_gnt;
  logic                 r_gpio_en, r_p2s_start, r_busy;
  logic [DATA_W-1:0]    r_gpio_data;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [PW-1:0]        w_idx;
  logic                 w_vld;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .vld (w_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_ack       <= '0;
      r_gnt       <= '0;
      r_gpio_en   <= 1'b0;
      r_gpio_data <= '0;
      r_p2s_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_vld) begin
            // A request beats a refresh expiring on the same edge.
            r_gnt       <= w_gnt;
            r_ack       <= w_gnt;
            r_gpio_en   <= 1'b1;
            r_gpio_data <= req_data[w_idx*DATA_W +: DATA_W];
            r_busy      <= 1'b1;
            r_ptr       <= (w_idx == PLAST) ? '0 : w_idx + 1'b1;
            r_rcnt      <= '0;
            r_state     <= LOAD;
          end else if (REFRESH_PERIOD != 0) begin
            if (r_rcnt == RLAST) begin
              // Re-shift the existing GPIO contents; no owner, no load.
              r_rcnt      <= '0;
              r_busy      <= 1'b1;
              r_p2s_start <= 1'b1;
              r_state     <= START;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        LOAD: begin
          r_ack       <= '0;
          r_gpio_en   <= 1'b0;
          r_p2s_start <= 1'b1;
          r_state     <= START;
        end
        START: begin
          r_p2s_start <= 1'b0;
          r_wcnt      <= SLAST;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - 1'b1;
          end else begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign gnt       = r_gnt;
  assign gpio_en   = r_gpio_en;
  assign gpio_data = r_gpio_data;
  assign p2s_start = r_p2s_start;
  assign busy      = r_busy;

endmodule

// File: tb/tb_led_gpio_arbiter.sv
// Directed bench: u_dut (SHIFT_CYCLES=4, refresh off) for arbitration,
// u_ref (SHIFT_CYCLES=4, REFRESH_PERIOD=16) for idle refresh.
module tb_led_gpio_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int S  = 4;
  localparam int P  = 16;

  logic              clk = 1'b0;
  logic              rst, rst2;
  logic [N-1:0]      req, req2;
  logic [N*DW-1:0]   req_data, req_data2;
  logic [N-1:0]      ack, gnt, ack2, gnt2;
  logic              gpio_en, p2s_start, busy, gpio_en2, p2s_start2, busy2;
  logic [DW-1:0]     gpio_data, gpio_data2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_gpio_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SHIFT_CYCLES(S), .REFRESH_PERIOD(0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .gnt(gnt),
    .gpio_en(gpio_en), .gpio_data(gpio_data), .p2s_start(p2s_start), .busy(busy)
  );

  led_gpio_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SHIFT_CYCLES(S), .REFRESH_PERIOD(P)) u_ref (
    .clk(clk), .rst(rst2), .req(req2), .req_data(req_data2), .ack(ack2), .gnt(gnt2),
    .gpio_en(gpio_en2), .gpio_data(gpio_data2), .p2s_start(p2s_start2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Drive a request, wait (bounded) for its ack, release, wait for idle.
  task automatic do_grant(input logic [N-1:0] r, output logic [N-1:0] a);
    a   = '0;
    req = r;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (ack != '0) begin a = ack; break; end
    end
    req = '0;
    for (int t = 0; t < 60; t++) begin
      if (!busy) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; req = '0; req2 = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW]  = 32'hD000_0000 | i;
      req_data2[i*DW +: DW] = 32'h1234_5670 | i;
    end
    tick(); tick();
    n_chk++;
    if ({ack, gnt, gpio_en, p2s_start, busy} !== '0 || gpio_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ack=%b gnt=%b en=%b p2s=%b busy=%b data=%h, want all 0",
               ack, gnt, gpio_en, p2s_start, busy, gpio_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int bc;
    req_data[1*DW +: DW] = 32'hA5A5_0F0F;
    req = 4'b0010;
    tick();
    n_chk++;
    if (ack !== 4'b0010 || gnt !== 4'b0010 || gpio_en !== 1'b1 || p2s_start !== 1'b0) begin
      n_err++;
      $display("FAIL single_grant: ack=%b gnt=%b en=%b p2s=%b, want 0010 0010 1 0",
               ack, gnt, gpio_en, p2s_start);
    end
    n_chk++;
    if (gpio_data !== 32'hA5A5_0F0F) begin
      n_err++;
      $display("FAIL single_data: got %h want a5a50f0f", gpio_data);
    end
    req = '0;
    tick();
    n_chk++;
    if (ack !== 4'b0000 || gpio_en !== 1'b0 || p2s_start !== 1'b1) begin
      n_err++;
      $display("FAIL single_start: ack=%b en=%b p2s=%b, want 0000 0 1", ack, gpio_en, p2s_start);
    end
    bc = 2;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (busy) bc++; else break;
    end
    n_chk++;
    if (bc != S + 2) begin
      n_err++;
      $display("FAIL single_busy_len: got %0d cycles want %0d", bc, S + 2);
    end
    n_chk++;
    if (gnt !== 4'b0000 || gpio_data !== 32'hA5A5_0F0F) begin
      n_err++;
      $display("FAIL single_idle_hold: gnt=%b data=%h, want 0000 a5a50f0f", gnt, gpio_data);
    end
  endtask

  task automatic test_contention();
    int gi[5];
    int gc[5];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int n;
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0;
    req = 4'b1111;
    for (int c = 1; c <= 100 && n < 5; c++) begin
      tick();
      if (ack != '0) begin gi[n] = oh_idx(ack); gc[n] = c; n++; end
    end
    req = '0;
    n_chk++;
    if (n != 5) begin
      n_err++;
      $display("FAIL contention_count: got %0d grants want 5", n);
    end
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (gi[i] != exp_o[i]) begin
        n_err++;
        $display("FAIL contention_order[%0d]: got %0d want %0d", i, gi[i], exp_o[i]);
      end
      if (i > 0) begin
        n_chk++;
        if (gc[i] - gc[i-1] != S + 3) begin
          n_err++;
          $display("FAIL contention_spacing[%0d]: got %0d want %0d", i, gc[i] - gc[i-1], S + 3);
        end
      end
    end
    for (int t = 0; t < 60 && busy; t++) tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] a;
    do_grant(4'b0100, a);
    n_chk++;
    if (a !== 4'b0100) begin n_err++; $display("FAIL fair_serve2: got %b want 0100", a); end
    do_grant(4'b0101, a);
    n_chk++;
    if (a !== 4'b0001) begin n_err++; $display("FAIL fair_0101_after2: got %b want 0001", a); end
    do_grant(4'b0110, a);
    n_chk++;
    if (a !== 4'b0010) begin n_err++; $display("FAIL fair_0110_after0: got %b want 0010", a); end
    do_grant(4'b0110, a);
    n_chk++;
    if (a !== 4'b0100) begin n_err++; $display("FAIL fair_0110_after1: got %b want 0100", a); end
  endtask

  task automatic test_refresh();
    int pc[3];
    int n;
    logic bad;
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    n = 0; bad = 1'b0;
    for (int t = 1; t <= 70 && n < 3; t++) begin
      tick();
      if (p2s_start2) begin
        pc[n] = t; n++;
        if (gpio_en2 !== 1'b0 || gnt2 !== '0 || busy2 !== 1'b1) bad = 1'b1;
      end
    end
    n_chk++;
    if (n != 3 || pc[0] != P) begin
      n_err++;
      $display("FAIL refresh_first: count=%0d first=%0d want 3 pulses first at %0d", n, pc[0], P);
    end
    n_chk++;
    if (n == 3 && (pc[1] - pc[0] != P + S + 1 || pc[2] - pc[1] != P + S + 1)) begin
      n_err++;
      $display("FAIL refresh_period: got %0d,%0d want %0d", pc[1] - pc[0], pc[2] - pc[1], P + S + 1);
    end
    n_chk++;
    if (bad) begin n_err++; $display("FAIL refresh_no_owner: gpio_en or gnt set during refresh"); end
    // Request lands on the same edge the refresh counter would expire.
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    repeat (P - 1) tick();
    req2 = 4'b0001;
    tick();
    req2 = '0;
    n_chk++;
    if (ack2 !== 4'b0001 || gpio_en2 !== 1'b1 || p2s_start2 !== 1'b0 || gpio_data2 !== 32'h1234_5670) begin
      n_err++;
      $display("FAIL refresh_vs_req: ack=%b en=%b p2s=%b data=%h, want 0001 1 0 12345670",
               ack2, gpio_en2, p2s_start2, gpio_data2);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] a;
    rst = 1'b1; tick(); rst = 1'b0;
    a = '0;
    req = 4'b0010;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (ack != '0) begin a = ack; break; end
    end
    req = '0;
    tick(); tick();
    n_chk++;
    if (a !== 4'b0010 || busy !== 1'b1 || p2s_start !== 1'b0 || gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL midrst_setup: ack=%b busy=%b p2s=%b gnt=%b, want 0010 1 0 0010", a, busy, p2s_start, gnt);
    end
    rst = 1'b1;
    req = 4'b1011;
    tick();
    n_chk++;
    if ({ack, gnt, gpio_en, p2s_start, busy} !== '0 || gpio_data !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: ack=%b gnt=%b en=%b p2s=%b busy=%b data=%h, want all 0",
               ack, gnt, gpio_en, p2s_start, busy, gpio_data);
    end
    rst = 1'b0;
    tick();
    req = '0;
    n_chk++;
    if (ack !== 4'b0001 || gpio_data !== 32'hD000_0000) begin
      n_err++;
      $display("FAIL midrst_regrant: ack=%b data=%h, want 0001 d0000000", ack, gpio_data);
    end
    for (int t = 0; t < 60 && busy; t++) tick();
  endtask

  task automatic test_withdrawn();
    logic seen3;
    seen3 = 1'b0;
    req = 4'b0001;
    tick();
    if (ack[3]) seen3 = 1'b1;
    req = '0;
    tick();
    req = 4'b1000;
    tick();
    req = '0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (ack[3]) seen3 = 1'b1;
    end
    n_chk++;
    if (seen3) begin n_err++; $display("FAIL withdrawn: ack[3] issued, want never"); end
    n_chk++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL withdrawn_idle: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_refresh();
    test_reset_mid();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
